whack_judge: RTL and testbench

//  Player-side responder to mole_state. Conditions the five push buttons and judges

---
 rtl/whack_judge.sv | 240 ++++++++++++++++++++++++
 tb/tb_whack_judge.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/whack_judge.sv
// -----------------------------------------------------------------------------
// whack_judge
// Player-side judge for the whack-a-mole game. Conditions the five raw push
// buttons (synchronizer + debounce + rising-edge detect), compares every press
// against the registered mole code and keeps the score, miss count and the
// game-over flag.
//
// Ports
//   clk         in   1  system clock
//   rst         in   1  synchronous, active-high reset
//   mole_pos    in   3  mole code 1..5 = holes A..E, 0/6/7 = no mole
//   btn         in   5  raw asynchronous buttons, btn[0]=A .. btn[4]=E
//   hit_pulse   out  1  one-cycle pulse per scored hit
//   miss_pulse  out  1  one-cycle pulse per scored miss
//   score_ones  out  4  BCD score units
//   score_tens  out  4  BCD score tens
//   misses      out  3  misses so far (0..MAX_MISSES)
//   game_over   out  1  level, set by the final miss, held until rst
// -----------------------------------------------------------------------------
module whack_judge #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MAX_MISSES      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] mole_pos,
  input  logic [4:0] btn,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [3:0] score_ones,
  output logic [3:0] score_tens,
  output logic [2:0] misses,
  output logic       game_over
);

  localparam int               CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]       MISS_LIMIT = 3'(MAX_MISSES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    JUDGED = 2'd2,
    OVER   = 2'd3
  } state_t;

  // Codes 1..5 name a hole; everything else means no mole is up.
  function automatic logic code_valid(input logic [2:0] code);
    return (code >= 3'd1) && (code <= 3'd5);
  endfunction

  // One-hot button expected for a mole code.
  function automatic logic [4:0] code_mask(input logic [2:0] code);
    logic [4:0] mask;
    case (code)
      3'd1:    mask = 5'b00001;
      3'd2:    mask = 5'b00010;
      3'd3:    mask = 5'b00100;
      3'd4:    mask = 5'b01000;
      3'd5:    mask = 5'b10000;
      default: mask = 5'b00000;
    endcase
    return mask;
  endfunction

  // Two-digit BCD increment that saturates at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] bcd);
    logic [7:0] res;
    if (bcd == 8'h99) begin
      res = bcd;
    end else if (bcd[3:0] == 4'd9) begin
      res = {bcd[7:4] + 4'd1, 4'd0};
    end else begin
      res = {bcd[7:4], bcd[3:0] + 4'd1};
    end
    return res;
  endfunction

  logic [4:0]       sync_r [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_r  [5];
  logic [4:0]       level_r;
  logic [4:0]       level_d_r;
  logic [4:0]       press_r;
  logic [2:0]       mole_q_r;
  logic [7:0]       score_r;
  state_t           state_r;
  state_t           state_next_s;
  state_t           base_next_s;
  logic [4:0]       synced_s;
  logic             any_press_s;
  logic             window_change_s;
  logic             hit_s;
  logic             miss_s;
  logic             last_miss_s;

  assign synced_s        = sync_r[SYNC_STAGES-1];
  assign any_press_s     = |press_r;
  assign window_change_s = (mole_pos != mole_q_r);
  assign score_ones      = score_r[3:0];
  assign score_tens      = score_r[7:4];

  // Button synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_r[k] <= 5'b00000;
      end
    end else begin
      sync_r[0] <= btn;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  // Debounce: a level is accepted after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_r <= 5'b00000;
      for (int i = 0; i < 5; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (synced_s[i] == level_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CNT_LAST) begin
          level_r[i] <= synced_s[i];
          cnt_r[i]   <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

  // Registered rising-edge press detect and mole code register.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_d_r <= 5'b00000;
      press_r   <= 5'b00000;
      mole_q_r  <= 3'd0;
    end else begin
      level_d_r <= level_r;
      press_r   <= level_r & ~level_d_r;
      mole_q_r  <= mole_pos;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state and judgement. A press in the same cycle as a window
  // change is judged against the old code and suppresses the escape miss.
  always_comb begin
    base_next_s  = state_r;
    hit_s        = 1'b0;
    miss_s       = 1'b0;
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_press_s) begin
          miss_s = 1'b1;
        end else begin
          miss_s = 1'b0;
        end
      end
      ARMED: begin
        if (any_press_s) begin
          base_next_s = JUDGED;
          if (press_r == code_mask(mole_q_r)) begin
            hit_s = 1'b1;
          end else begin
            miss_s = 1'b1;
          end
        end else if (window_change_s) begin
          miss_s = 1'b1;
        end else begin
          base_next_s = ARMED;
        end
      end
      JUDGED: begin
        base_next_s = JUDGED;
      end
      OVER: begin
        base_next_s = OVER;
      end
      default: begin
        base_next_s = IDLE;
      end
    endcase

    last_miss_s = miss_s && (misses == (MISS_LIMIT - 3'd1));

    if (last_miss_s) begin
      state_next_s = OVER;
    end else if ((state_r != OVER) && window_change_s) begin
      state_next_s = code_valid(mole_pos) ? ARMED : IDLE;
    end else begin
      state_next_s = base_next_s;
    end
  end

  // Registered outputs: pulses, score, miss count and game-over flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      score_r    <= 8'h00;
      misses     <= 3'd0;
      game_over  <= 1'b0;
    end else begin
      hit_pulse  <= hit_s;
      miss_pulse <= miss_s;
      if (hit_s) begin
        score_r <= bcd_inc(score_r);
      end else begin
        score_r <= score_r;
      end
      if (miss_s) begin
        misses <= misses + 3'd1;
      end else begin
        misses <= misses;
      end
      if (last_miss_s) begin
        game_over <= 1'b1;
      end else begin
        game_over <= game_over;
      end
    end
  end

endmodule

// File: tb/tb_whack_judge.sv
// -----------------------------------------------------------------------------
// tb_whack_judge
// Directed self-checking bench for whack_judge with SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, MAX_MISSES=3 (pin-to-pulse latency 8 cycles).
// -----------------------------------------------------------------------------
module tb_whack_judge;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] mole_pos;
  logic [4:0] btn;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [3:0] score_ones;
  logic [3:0] score_tens;
  logic [2:0] misses;
  logic       game_over;

  int checks = 0;
  int errors = 0;
  int exp_score = 0;
  int hit_k = 0;

  whack_judge #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .MAX_MISSES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mole_pos(mole_pos),
    .btn(btn),
    .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse),
    .score_ones(score_ones),
    .score_tens(score_tens),
    .misses(misses),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Advance one clock; sampling happens 1 time unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Run n cycles, counting hit and miss pulses seen.
  task automatic run(input int n, output int h, output int m);
    h = 0;
    m = 0;
    repeat (n) begin
      tick();
      if (hit_pulse === 1'b1) h++;
      if (miss_pulse === 1'b1) m++;
    end
  endtask

  // Expected BCD score from the integer scoreboard.
  function automatic logic [7:0] exp_bcd(input int s);
    return {4'(s / 10), 4'(s % 10)};
  endfunction

  // Raise a mole, press its button, release and let the release settle.
  task automatic do_hit(input logic [2:0] code, output int h);
    int h2, m, m2;
    mole_pos = code;
    tick();
    tick();
    btn = 5'b00001 << (code - 3'd1);
    run(10, h, m);
    btn = 5'b00000;
    run(8, h2, m2);
    h = h + h2;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    mole_pos = 3'd0;
    btn = 5'b00000;
    tick();
    tick();
    checks++;
    if ({hit_pulse, miss_pulse, score_tens, score_ones, misses, game_over} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {hit_pulse, miss_pulse, score_tens, score_ones, misses, game_over});
    end
    rst = 1'b0;
  endtask

  task automatic test_hit_latency;
    int early, h, m;
    mole_pos = 3'd2;
    tick();
    tick();
    btn = 5'b00010;
    early = 0;
    repeat (7) begin
      tick();
      if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0) early++;
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL hit_early: got %0d pulses before cycle 8 expected 0", early);
    end
    tick();
    checks++;
    if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0) begin
      errors++;
      $display("FAIL hit_cycle8: got hit=%b miss=%b expected hit=1 miss=0", hit_pulse, miss_pulse);
    end
    exp_score = 1;
    checks++;
    if ({score_tens, score_ones} !== exp_bcd(exp_score)) begin
      errors++;
      $display("FAIL score_first_hit: got %h expected %h", {score_tens, score_ones}, exp_bcd(exp_score));
    end
    tick();
    checks++;
    if (hit_pulse !== 1'b0) begin
      errors++;
      $display("FAIL hit_one_cycle: got hit=%b expected 0", hit_pulse);
    end
    btn = 5'b00000;
    run(8, h, m);
  endtask

  task automatic test_bounce;
    int h, m;
    int th, tm;
    mole_pos = 3'd3;
    tick();
    tick();
    th = 0;
    tm = 0;
    for (int i = 0; i < 8; i++) begin
      btn = ((i % 4) < 2) ? 5'b00100 : 5'b00000;
      tick();
      if (hit_pulse === 1'b1) th++;
      if (miss_pulse === 1'b1) tm++;
    end
    btn = 5'b00100;
    run(12, h, m);
    checks++;
    if (th !== 0 || tm !== 0) begin
      errors++;
      $display("FAIL bounce_no_press: got hits=%0d misses=%0d during chatter expected 0/0", th, tm);
    end
    checks++;
    if (h !== 1 || m !== 0) begin
      errors++;
      $display("FAIL bounce_one_hit: got hits=%0d misses=%0d expected 1/0", h, m);
    end
    exp_score = 2;
    checks++;
    if ({score_tens, score_ones} !== exp_bcd(exp_score)) begin
      errors++;
      $display("FAIL bounce_score: got %h expected %h", {score_tens, score_ones}, exp_bcd(exp_score));
    end
    btn = 5'b00000;
    run(8, h, m);
  endtask

  task automatic test_miss;
    int h, m;
    mole_pos = 3'd4;
    run(2, h, m);
    checks++;
    if (h !== 0 || m !== 0) begin
      errors++;
      $display("FAIL judged_to_armed: got hits=%0d misses=%0d expected 0/0", h, m);
    end
    mole_pos = 3'd5;
    tick();
    checks++;
    if (miss_pulse !== 1'b1 || hit_pulse !== 1'b0 || misses !== 3'd1) begin
      errors++;
      $display("FAIL escape_miss: got miss=%b hit=%b misses=%0d expected 1/0/1",
               miss_pulse, hit_pulse, misses);
    end
    btn = 5'b10001;
    run(10, h, m);
    checks++;
    if (h !== 0 || m !== 1 || misses !== 3'd2 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL double_press_miss: got hits=%0d misses_pulses=%0d misses=%0d go=%b expected 0/1/2/0",
               h, m, misses, game_over);
    end
    btn = 5'b00000;
    run(8, h, m);
  endtask

  task automatic test_score_saturate;
    int h, total;
    total = 0;
    while (exp_score < 99) begin
      do_hit(3'((hit_k % 5) + 1), h);
      hit_k++;
      total += h;
      exp_score++;
      if (exp_score == 10) begin
        checks++;
        if ({score_tens, score_ones} !== 8'h10) begin
          errors++;
          $display("FAIL bcd_carry: got %h expected 10", {score_tens, score_ones});
        end
      end
    end
    checks++;
    if (total !== 97 || {score_tens, score_ones} !== 8'h99 || misses !== 3'd2) begin
      errors++;
      $display("FAIL reach_99: got hits=%0d score=%h misses=%0d expected 97/99/2",
               total, {score_tens, score_ones}, misses);
    end
    do_hit(3'((hit_k % 5) + 1), h);
    hit_k++;
    checks++;
    if (h !== 1 || {score_tens, score_ones} !== 8'h99) begin
      errors++;
      $display("FAIL saturate_99: got hits=%0d score=%h expected 1/99", h, {score_tens, score_ones});
    end
  endtask

  task automatic test_game_over;
    int h, m;
    mole_pos = 3'd0;
    run(2, h, m);
    btn = 5'b00001;
    run(10, h, m);
    checks++;
    if (h !== 0 || m !== 1 || misses !== 3'd3 || game_over !== 1'b1) begin
      errors++;
      $display("FAIL final_miss: got hits=%0d miss_pulses=%0d misses=%0d go=%b expected 0/1/3/1",
               h, m, misses, game_over);
    end
    btn = 5'b00000;
    run(8, h, m);
    mole_pos = 3'd1;
    run(2, h, m);
    btn = 5'b00001;
    run(10, h, m);
    checks++;
    if (h !== 0 || m !== 0 || {score_tens, score_ones} !== 8'h99 || misses !== 3'd3 || game_over !== 1'b1) begin
      errors++;
      $display("FAIL over_frozen: got hits=%0d misses_p=%0d score=%h misses=%0d go=%b expected 0/0/99/3/1",
               h, m, {score_tens, score_ones}, misses, game_over);
    end
    btn = 5'b00000;
    run(8, h, m);
  endtask

  task automatic test_back_to_back;
    int h, m, early;
    rst = 1'b1;
    tick();
    checks++;
    if ({hit_pulse, miss_pulse, score_tens, score_ones, misses, game_over} !== 16'h0000) begin
      errors++;
      $display("FAIL midgame_reset: got %b expected all zero",
               {hit_pulse, miss_pulse, score_tens, score_ones, misses, game_over});
    end
    rst = 1'b0;
    mole_pos = 3'd1;
    tick();
    tick();
    btn = 5'b00001;
    early = 0;
    repeat (7) begin
      tick();
      if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0) early++;
    end
    mole_pos = 3'd2;
    tick();
    checks++;
    if (early !== 0 || hit_pulse !== 1'b1 || miss_pulse !== 1'b0) begin
      errors++;
      $display("FAIL coincident_hit: got early=%0d hit=%b miss=%b expected 0/1/0", early, hit_pulse, miss_pulse);
    end
    run(6, h, m);
    checks++;
    if (h !== 0 || m !== 0 || {score_tens, score_ones} !== 8'h01) begin
      errors++;
      $display("FAIL no_escape_miss: got hits=%0d misses=%0d score=%h expected 0/0/01",
               h, m, {score_tens, score_ones});
    end
    btn = 5'b00000;
    run(8, h, m);
    btn = 5'b00010;
    run(10, h, m);
    checks++;
    if (h !== 1 || m !== 0 || {score_tens, score_ones} !== 8'h02) begin
      errors++;
      $display("FAIL new_window_armed: got hits=%0d misses=%0d score=%h expected 1/0/02",
               h, m, {score_tens, score_ones});
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({hit_pulse, miss_pulse, score_tens, score_ones, misses, game_over} !== 16'h0000) begin
      errors++;
      $display("FAIL final_reset: got %b expected all zero",
               {hit_pulse, miss_pulse, score_tens, score_ones, misses, game_over});
    end
    rst = 1'b0;
    btn = 5'b00000;
  endtask

  initial begin
    test_reset();
    test_hit_latency();
    test_bounce();
    test_miss();
    test_score_saturate();
    test_game_over();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
